sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_rr.sv | 15 +
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths and FSM encoding for the two-port SRAM arbiter.
package sram_arb_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module sram_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM with active-low controls.
// Optional build macro SRAM_ARB_WRITE_PROTECT_EN blocks port-0 writes below WP_LIMIT.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] WP_LIMIT    = 20'd512
) (
    input  logic              clk50M,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              busy,
    output logic              wp_violation
);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic                suppress_q, suppress_d;
    logic                rr_grant;
    logic                start_access;
    logic                wp_hit;
    logic                drive_data;

    sram_arb_rr u_rr (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_q),
        .grant      (rr_grant)
    );

    assign start_access = (state_q == ST_IDLE) && (p0_req || p1_req);

`ifdef SRAM_ARB_WRITE_PROTECT_EN
    logic wp_q, wp_d;

    assign wp_hit = !rr_grant && p0_we && (p0_addr < WP_LIMIT);

    always_comb begin
        wp_d = wp_q;
        if (start_access && wp_hit) begin
            wp_d = 1'b1;
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            wp_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
        end
    end

    assign wp_violation = wp_q;
`else
    // WP_LIMIT has no function without write protection.
    logic unused_wp_limit;

    assign unused_wp_limit = ^WP_LIMIT;
    assign wp_hit          = 1'b0;
    assign wp_violation    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        suppress_d   = suppress_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_access) begin
                    state_d      = ST_SETUP;
                    grant_d      = rr_grant;
                    last_grant_d = rr_grant;
                    we_d         = rr_grant ? p1_we    : p0_we;
                    addr_d       = rr_grant ? p1_addr  : p0_addr;
                    wdata_d      = rr_grant ? p1_wdata : p0_wdata;
                    suppress_d   = wp_hit;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wcnt_d  = '0;
            end
            ST_ACCESS: begin
                if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_DONE;
                    // The last ACCESS cycle is where read data has had the full strobe time.
                    if (!we_q) begin
                        if (grant_q) begin
                            p1_rdata_d = ram_data;
                        end else begin
                            p0_rdata_d = ram_data;
                        end
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            suppress_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            suppress_q   <= suppress_d;
        end
    end

    // Write data stays on the bus through DONE so the SRAM sees hold time after ram_we rises.
    always_comb begin
        ram_ce     = 1'b1;
        ram_oe     = 1'b1;
        ram_we     = 1'b1;
        drive_data = 1'b0;
        unique case (state_q)
            ST_SETUP: begin
                ram_ce     = 1'b0;
                ram_oe     = we_q;
                drive_data = we_q;
            end
            ST_ACCESS: begin
                ram_ce     = 1'b0;
                ram_oe     = we_q;
                ram_we     = !we_q || suppress_q;
                drive_data = we_q;
            end
            ST_DONE: begin
                ram_ce     = 1'b0;
                drive_data = we_q;
            end
            default: begin
                ram_ce = 1'b1;
            end
        endcase
    end

    assign ram_data = drive_data ? wdata_q : {DATA_W{1'bz}};
    assign ram_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign p0_ack   = (state_q == ST_DONE) && !grant_q;
    assign p1_ack   = (state_q == ST_DONE) && grant_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Random two-port traffic against a transaction-level model with a scoreboard;
// a second instance exercises WAIT_CYCLES=3.
module tb_sram_arbiter;
    localparam int          W      = 1;
    localparam int          W3     = 3;
    localparam logic [19:0] WP_LIM = 20'd512;

    typedef struct {
        logic        port;
        logic        is_write;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cycle;
        int          we_low;
        int          oe_low;
        logic        wp;
    } exp_t;

    logic        clk50M = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [19:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic [19:0] ram_addr;
    wire  [31:0] ram_data;
    logic        ram_ce, ram_oe, ram_we, busy, wp_violation;

    logic        q_p1_req;
    logic [19:0] q_p1_addr;
    logic [31:0] q_p0_rdata, q_p1_rdata;
    logic        q_p0_ack, q_p1_ack;
    logic [19:0] q_ram_addr;
    wire  [31:0] q_ram_data;
    logic        q_ram_ce, q_ram_oe, q_ram_we, q_busy, q_wp;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic        park_en = 1'b0;
    exp_t        sb_q[$];
    logic [31:0] sram [logic [19:0]];
    logic [31:0] ref_mem [logic [19:0]];
    logic [31:0] sram_rd = '0;
    logic        model_last = 1'b1;
    logic        model_wp = 1'b0;
    int          we_low_cnt = 0;
    int          oe_low_cnt = 0;
    int          oe3_cnt = 0;
    logic [31:0] held_rdata [2];
    logic [19:0] pool [8] = '{20'h00000, 20'h001FF, 20'h00200, 20'h00400,
                              20'h12345, 20'h00010, 20'h80000, 20'hFFFF0};

    sram_arbiter #(.WAIT_CYCLES(W), .WP_LIMIT(WP_LIM)) dut (
        .clk50M(clk50M), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce(ram_ce), .ram_oe(ram_oe),
        .ram_we(ram_we), .busy(busy), .wp_violation(wp_violation)
    );

    sram_arbiter #(.WAIT_CYCLES(W3), .WP_LIMIT(WP_LIM)) dut3 (
        .clk50M(clk50M), .rst(rst),
        .p0_req(1'b0), .p0_we(1'b0), .p0_addr(20'h0), .p0_wdata(32'h0),
        .p0_rdata(q_p0_rdata), .p0_ack(q_p0_ack),
        .p1_req(q_p1_req), .p1_we(1'b0), .p1_addr(q_p1_addr), .p1_wdata(32'h0),
        .p1_rdata(q_p1_rdata), .p1_ack(q_p1_ack),
        .ram_addr(q_ram_addr), .ram_data(q_ram_data), .ram_ce(q_ram_ce), .ram_oe(q_ram_oe),
        .ram_we(q_ram_we), .busy(q_busy), .wp_violation(q_wp)
    );

    always #5 clk50M = ~clk50M;
    always @(posedge clk50M) cyc <= cyc + 1;

    // Power-up content of the SRAM device models for never-written words.
    function automatic logic [31:0] init_word(input logic [19:0] a);
        return {12'hA5C, a} ^ 32'h0F0F_0F0F;
    endfunction

    // Asynchronous SRAM device models: drive on read strobe, capture while ram_we is low.
    assign ram_data   = (!ram_ce && !ram_oe && ram_we) ? sram_rd : 32'hzzzz_zzzz;
    assign ram_data   = park_en ? 32'h0 : 32'hzzzz_zzzz;
    assign q_ram_data = (!q_ram_ce && !q_ram_oe && q_ram_we) ? init_word(q_ram_addr) : 32'hzzzz_zzzz;

    always @(posedge clk50M) begin
        #1;
        sram_rd = sram.exists(ram_addr) ? sram[ram_addr] : init_word(ram_addr);
    end

    always @(negedge clk50M) begin
        if (!ram_ce && !ram_we) sram[ram_addr] = ram_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: each granted access in order, as the requester would see it complete.
    task automatic predict(input logic port, input logic we, input logic [19:0] a,
                           input logic [31:0] d, input int ack_cycle);
        exp_t e;
        logic blocked;
        blocked = 1'b0;
`ifdef SRAM_ARB_WRITE_PROTECT_EN
        blocked = (port == 1'b0) && we && (a < WP_LIM);
`endif
        e.port      = port;
        e.is_write  = we;
        e.addr      = a;
        e.wdata     = d;
        e.ack_cycle = ack_cycle;
        e.rdata     = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        e.we_low    = (we && !blocked) ? W : 0;
        e.oe_low    = we ? 0 : W + 1;
        if (we && !blocked) ref_mem[a] = d;
        model_wp    = model_wp | blocked;
        e.wp        = model_wp;
        model_last  = port;
        sb_q.push_back(e);
    endtask

    // Called one time unit after a rising edge with the arbiter idle.
    task automatic applyStimulus(input logic [1:0] mask,
                                 input logic w0, input logic [19:0] a0, input logic [31:0] d0,
                                 input logic w1, input logic [19:0] a1, input logic [31:0] d1);
        logic       first;
        logic [1:0] pending;
        logic [1:0] ackd;
        int         start;
        int         budget;
        start = cyc;
        first = (mask == 2'b11) ? ~model_last : mask[1];
        predict(first, first ? w1 : w0, first ? a1 : a0, first ? d1 : d0, start + 2 + W);
        if (mask == 2'b11)
            predict(~first, first ? w0 : w1, first ? a0 : a1, first ? d0 : d1, start + 5 + 2 * W);
        p0_req = mask[0]; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = mask[1]; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        pending = mask;
        budget  = 4 * (3 + W);
        while (pending != 2'b00 && budget > 0) begin
            @(negedge clk50M);
            ackd = {p1_ack, p0_ack} & pending;
            @(posedge clk50M);
            #1;
            if (ackd[0]) begin p0_req = 1'b0; pending[0] = 1'b0; end
            if (ackd[1]) begin p1_req = 1'b0; pending[1] = 1'b0; end
            budget--;
        end
        if (pending != 2'b00) begin
            checkOutput("ack_timeout", {30'b0, pending}, 32'h0);
            p0_req = 1'b0;
            p1_req = 1'b0;
        end
    endtask

    task automatic checkAck();
        exp_t e;
        if (p0_ack && p1_ack) checkOutput("dual_ack", 32'h3, 32'h1);
        if (sb_q.size() == 0) begin
            checkOutput("unexpected_ack", {30'b0, p1_ack, p0_ack}, 32'h0);
        end else begin
            e = sb_q.pop_front();
            checkOutput("ack_port", {31'b0, p1_ack}, {31'b0, e.port});
            checkOutput("ack_cycle", cyc, e.ack_cycle);
            if (!e.is_write) held_rdata[e.port] = e.rdata;
            checkOutput("p0_rdata", p0_rdata, held_rdata[0]);
            checkOutput("p1_rdata", p1_rdata, held_rdata[1]);
            checkOutput("we_low_cycles", we_low_cnt, e.we_low);
            checkOutput("oe_low_cycles", oe_low_cnt, e.oe_low);
            checkOutput("wp_violation", {31'b0, wp_violation}, {31'b0, e.wp});
        end
        we_low_cnt = 0;
        oe_low_cnt = 0;
    endtask

    always @(negedge clk50M) begin
        if (rst) begin
            we_low_cnt    = 0;
            oe_low_cnt    = 0;
            held_rdata[0] = '0;
            held_rdata[1] = '0;
        end else if (mon_en) begin
            if (!ram_we) we_low_cnt++;
            if (!ram_oe) oe_low_cnt++;
            checkOutput("oe_we_overlap", {31'b0, !ram_oe && !ram_we}, 32'h0);
            if (!ram_oe) checkOutput("read_bus", ram_data, sram_rd);
            if (sb_q.size() > 0 && (!ram_oe || !ram_we)) checkOutput("ram_addr", {12'h0, ram_addr}, {12'h0, sb_q[0].addr});
            if (sb_q.size() > 0 && !ram_we) checkOutput("write_bus", ram_data, sb_q[0].wdata);
            if (p0_ack || p1_ack) checkAck();
        end
    end

    always @(negedge clk50M) begin
        if (rst) begin
            oe3_cnt = 0;
        end else if (mon_en) begin
            if (!q_ram_oe) oe3_cnt++;
            checkOutput("w3_oe_we_overlap", {31'b0, !q_ram_oe && !q_ram_we}, 32'h0);
            if (!q_ram_oe) checkOutput("w3_read_bus", q_ram_data, init_word(q_ram_addr));
        end
    end

    initial begin
        int   start;
        int   budget;
        logic seen;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        q_p1_req = 1'b0; q_p1_addr = '0;
        repeat (3) @(posedge clk50M);
        #1;
        checkOutput("reset_ctrl", {29'b0, ram_ce, ram_oe, ram_we}, 32'h7);
        checkOutput("reset_addr", {12'h0, ram_addr}, 32'h0);
        checkOutput("reset_status", {28'b0, busy, p0_ack, p1_ack, wp_violation}, 32'h0);
        checkOutput("reset_rdata", p0_rdata | p1_rdata, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk50M);
        #1;

        $display("[TB] directed write/read and tie sequences");
        applyStimulus(2'b01, 1'b1, 20'h00400, 32'hDEADBEEF, 1'b0, 20'h0, 32'h0);
        checkOutput("sram_word", sram[20'h00400], 32'hDEADBEEF);
        applyStimulus(2'b10, 1'b0, 20'h0, 32'h0, 1'b0, 20'h00400, 32'h0);
        repeat (2) applyStimulus(2'b11, 1'b1, 20'h00010, $urandom(), 1'b1, 20'h12345, $urandom());
        applyStimulus(2'b11, 1'b0, 20'h12345, 32'h0, 1'b0, 20'h00010, 32'h0);

        $display("[TB] write-protect boundary sequence");
        applyStimulus(2'b01, 1'b1, 20'h001FF, 32'h1111_2222, 1'b0, 20'h0, 32'h0);
        applyStimulus(2'b01, 1'b1, 20'h00200, 32'h3333_4444, 1'b0, 20'h0, 32'h0);
        applyStimulus(2'b10, 1'b0, 20'h0, 32'h0, 1'b1, 20'h00000, 32'h5555_6666);
        applyStimulus(2'b11, 1'b0, 20'h001FF, 32'h0, 1'b0, 20'h00200, 32'h0);
        applyStimulus(2'b01, 1'b0, 20'h00000, 32'h0, 1'b0, 20'h0, 32'h0);

        $display("[TB] random traffic");
        for (int r = 0; r < 60; r++) begin
            applyStimulus(2'($urandom_range(1, 3)),
                          1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom(),
                          1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom());
        end

        $display("[TB] reset during a write access");
        start = cyc;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 20'hFFFFF; p0_wdata = 32'hA5A5_5A5A;
        @(posedge clk50M);
        #1;
        @(posedge clk50M);
        #1;
        checkOutput("abort_in_access", {31'b0, ram_we}, 32'h0);
        rst = 1'b1;
        p0_req = 1'b0;
        @(posedge clk50M);
        #1;
        park_en = 1'b1;
        #1;
        checkOutput("abort_ctrl", {29'b0, ram_ce, ram_oe, ram_we}, 32'h7);
        checkOutput("abort_bus_released", ram_data, 32'h0);
        checkOutput("abort_addr", {12'h0, ram_addr}, 32'h0);
        checkOutput("abort_status", {28'b0, busy, p0_ack, p1_ack, wp_violation}, 32'h0);
        checkOutput("abort_rdata", p0_rdata | p1_rdata, 32'h0);
        checkOutput("abort_cycle", cyc, start + 3);
        park_en = 1'b0;
        rst = 1'b0;
        model_last = 1'b1;
        model_wp = 1'b0;
        @(posedge clk50M);
        #1;
        applyStimulus(2'b10, 1'b0, 20'h0, 32'h0, 1'b0, 20'h00400, 32'h0);
        applyStimulus(2'b11, 1'b0, 20'h00200, 32'h0, 1'b1, 20'h80000, $urandom());
        applyStimulus(2'b11, 1'b1, 20'h00400, $urandom(), 1'b0, 20'h00400, 32'h0);

        $display("[TB] WAIT_CYCLES=3 single read");
        start = cyc;
        q_p1_req = 1'b1;
        q_p1_addr = 20'h00123;
        seen = 1'b0;
        budget = 20;
        while (!seen && budget > 0) begin
            @(negedge clk50M);
            if (q_p1_ack) begin
                seen = 1'b1;
                checkOutput("w3_ack_cycle", cyc, start + 2 + W3);
                checkOutput("w3_rdata", q_p1_rdata, init_word(20'h00123));
                checkOutput("w3_oe_low_cycles", oe3_cnt, W3 + 1);
                checkOutput("w3_p0_untouched", {q_p0_rdata[30:0], q_p0_ack}, 32'h0);
            end
            budget--;
        end
        if (!seen) checkOutput("w3_ack_timeout", {31'b0, seen}, 32'h1);
        @(posedge clk50M);
        #1;
        q_p1_req = 1'b0;
        repeat (3) @(posedge clk50M);
        #1;
        checkOutput("sb_drained", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
